// File: rtl/gauss_upsampler.sv
// rtl/gauss_upsampler.sv - 2x nearest-neighbour up-sampler draining the Gaussian output FIFO
//
// Purpose:
//   Reads down-sampled pixels from the FIFO read port and emits a raster
//   stream in which every pixel is repeated horizontally and every line is
//   repeated vertically. The first copy of a line comes straight from the
//   FIFO and is written into a line buffer as it passes. The second copy is
//   replayed from that buffer.
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst        in   synchronous active-low reset
//   empty      in   FIFO empty flag
//   rd_en      out  FIFO read strobe, one pixel per assertion
//   valid      in   FIFO read data valid, one cycle after rd_en
//   din        in   FIFO read data [DW-1:0]
//   dout       out  up-sampled pixel [DW-1:0]
//   valid_out  out  dout valid
//   ready_out  in   downstream accept
//   eol        out  last pixel of an output line
//   eof        out  last pixel of an output frame
//   underrun_cnt out [15:0] starved-read cycles in the current frame
//                   (only when GAUSS_UPSAMPLE_UNDERRUN_CNT_EN is defined)
//
// Optional feature macro: GAUSS_UPSAMPLE_UNDERRUN_CNT_EN

module gauss_upsampler #(
  parameter int IN_W = 400,
  parameter int IN_H = 300,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          empty,
  output logic          rd_en,
  input  logic          valid,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid_out,
  input  logic          ready_out,
  output logic          eol,
  output logic          eof
`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   underrun_cnt
`endif
);

  localparam int CW = $clog2(2 * IN_W);
  localparam int RW = $clog2(IN_H) + 1;
  localparam int AW = CW - 1;

  localparam logic [CW-1:0] IN_W_C   = CW'(IN_W);
  localparam logic [CW-1:0] LAST_COL = CW'(2 * IN_W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_REPLAY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] row_q, row_d;
  logic          outstanding_q, outstanding_d;
  logic          hold_full_q, hold_full_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          phase_q, phase_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_out_q, valid_out_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [DW-1:0] line_buf [IN_W];

  logic          slot_free;
  logic          in_valid;
  logic          load;
  logic [DW-1:0] load_pix;
  logic          hold_empty;
  logic          cur_phase;
  logic          last_col;
  logic          rd_en_c;
  logic          buf_we;
  logic [AW-1:0] rd_addr;

`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
  logic [15:0]   underrun_q, underrun_d;
`endif

  // Output register can take a new pixel when empty or being drained now.
  assign slot_free = !valid_out_q || ready_out;
  // A valid without a read in flight (spurious or pre-reset) is dropped.
  assign in_valid  = valid && outstanding_q;
  assign last_col  = (out_col_q == LAST_COL);

  always_comb begin
    state_d       = state_q;
    in_col_d      = in_col_q;
    out_col_d     = out_col_q;
    row_d         = row_q;
    outstanding_d = outstanding_q;
    hold_full_d   = hold_full_q;
    hold_d        = hold_q;
    phase_d       = phase_q;
    dout_d        = dout_q;
    valid_out_d   = valid_out_q;
    eol_d         = eol_q;
    eof_d         = eof_q;
    load          = 1'b0;
    load_pix      = hold_q;
    cur_phase     = hold_full_q && phase_q;
    hold_empty    = !hold_full_q;
    rd_en_c       = 1'b0;
    buf_we        = 1'b0;
`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
    underrun_d    = underrun_q;
`endif

    if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
      eol_d       = 1'b0;
      eof_d       = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d   = S_FETCH;
          in_col_d  = '0;
          out_col_d = '0;
          row_d     = '0;
          phase_d   = 1'b0;
`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
          underrun_d = '0;
`endif
        end
      end

      S_FETCH: begin
        // Arriving FIFO data bypasses the hold so the first copy leaves
        // one cycle after valid; the hold only keeps it for the second copy.
        load = (hold_full_q || in_valid) && slot_free;
        // The hold counts as free in the cycle its second copy is taken,
        // letting the next read overlap and sustain one pixel per cycle.
        hold_empty = !hold_full_q || (load && phase_q);
        rd_en_c = !empty && !outstanding_q && hold_empty && (in_col_q < IN_W_C);

`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
        if (empty && hold_empty && !outstanding_q && (in_col_q < IN_W_C) &&
            (underrun_q != 16'hFFFF)) begin
          underrun_d = underrun_q + 16'd1;
        end
`endif

        if (in_valid) begin
          hold_d        = din;
          hold_full_d   = 1'b1;
          phase_d       = 1'b0;
          buf_we        = 1'b1;
          in_col_d      = in_col_q + COL_ONE;
          outstanding_d = 1'b0;
        end
        if (rd_en_c) begin
          outstanding_d = 1'b1;
        end

        if (load) begin
          load_pix = hold_full_q ? hold_q : din;
          if (cur_phase) begin
            hold_full_d = 1'b0;
            phase_d     = 1'b0;
          end else begin
            hold_full_d = 1'b1;
            phase_d     = 1'b1;
          end
          eol_d = last_col;
          eof_d = 1'b0;
          if (last_col) begin
            out_col_d = '0;
            state_d   = S_REPLAY;
          end else begin
            out_col_d = out_col_q + COL_ONE;
          end
        end
      end

      S_REPLAY: begin
        load     = slot_free;
        load_pix = rdata_q;
        if (load) begin
          eol_d = last_col;
          eof_d = last_col && (row_q == LAST_ROW);
          if (last_col) begin
            out_col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d    = row_q + ROW_ONE;
              in_col_d = '0;
              state_d  = S_FETCH;
            end
          end else begin
            out_col_d = out_col_q + COL_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      dout_d      = load_pix;
      valid_out_d = 1'b1;
    end
  end

  // Prefetch: the buffer is addressed with the column that will be current
  // next cycle, so rdata_q always holds the pixel for out_col_q.
  assign rd_addr = out_col_d[CW-1:1];

  always_comb begin
    rdata_d = line_buf[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[in_col_q[AW-1:0]] <= din;
    end
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      in_col_q      <= '0;
      out_col_q     <= '0;
      row_q         <= '0;
      outstanding_q <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_q        <= '0;
      phase_q       <= 1'b0;
      dout_q        <= '0;
      valid_out_q   <= 1'b0;
      eol_q         <= 1'b0;
      eof_q         <= 1'b0;
`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
      underrun_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_col_q      <= in_col_d;
      out_col_q     <= out_col_d;
      row_q         <= row_d;
      outstanding_q <= outstanding_d;
      hold_full_q   <= hold_full_d;
      hold_q        <= hold_d;
      phase_q       <= phase_d;
      dout_q        <= dout_d;
      valid_out_q   <= valid_out_d;
      eol_q         <= eol_d;
      eof_q         <= eof_d;
`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
      underrun_q    <= underrun_d;
`endif
    end
  end

  assign rd_en     = rd_en_c;
  assign dout      = dout_q;
  assign valid_out = valid_out_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
`ifdef GAUSS_UPSAMPLE_UNDERRUN_CNT_EN
  assign underrun_cnt = underrun_q;
`endif

endmodule
